// File: rtl/lsu_aligner.sv
// Load/store alignment unit between execute and the data bus: byte-enabled bus beats,
// optional two-beat splitting of cross-word accesses, and sign/zero extension of loads.
module lsu_aligner #(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [XLEN-1:0]   req_wdata_i,
  input  logic [4:0]        req_rd_i,
  output logic              bus_valid_o,
  input  logic              bus_ready_i,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [XLEN/8-1:0] bus_be_o,
  output logic [XLEN-1:0]   bus_wdata_o,
  input  logic              bus_rvalid_i,
  input  logic [XLEN-1:0]   bus_rdata_i,
  output logic              wb_valid_o,
  output logic [4:0]        wb_rd_o,
  output logic [XLEN-1:0]   wb_data_o,
  output logic              done_o,
  output logic              fault_o,
  output logic [2:0]        dbg_state_o
);

  localparam int W     = XLEN / 8;
  localparam int OFF_W = $clog2(W);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE0, S_WAIT0, S_ISSUE1, S_WAIT1, S_DONE, S_FAULT
  } state_t;

  // Handshakes: a bus beat transfers on a clk edge where bus_valid_o & bus_ready_i;
  // the command fields only change on that edge. A request is taken on req_valid_i & req_ready_o.

  state_t             r_state;
  logic               r_we;
  logic [2:0]         r_f3;
  logic [4:0]         r_rd;
  logic [OFF_W-1:0]   r_off;
  logic               r_split;
  logic [ADDR_W-1:0]  r_addr1;
  logic [W-1:0]       r_be1;
  logic [XLEN-1:0]    r_wdata1;
  logic [XLEN-1:0]    r_rdata0;

  logic [1:0]         w_sz;
  logic [OFF_W-1:0]   w_off;
  logic [4:0]         w_end;
  logic               w_split;
  logic [2:0]         w_lowmask;
  logic               w_misaligned;
  logic               w_legal;
  logic               w_fault;
  logic [2*W-1:0]     w_mask;
  logic [2*W-1:0]     w_be2;
  logic [2*XLEN-1:0]  w_wdata2;
  logic [ADDR_W-1:0]  w_base;
  logic [XLEN-1:0]    w_rd_lo;
  logic [XLEN-1:0]    w_rd_hi;
  logic [2*XLEN-1:0]  w_pair;
  logic [XLEN-1:0]    w_wb_data;

  assign dbg_state_o = r_state;
  assign req_ready_o = (r_state == S_IDLE);

  assign w_sz         = req_funct3_i[1:0];
  assign w_off        = req_addr_i[OFF_W-1:0];
  assign w_end        = 5'(w_off) + (5'd1 << w_sz);
  assign w_split      = w_end > 5'(W);
  assign w_lowmask    = 3'((4'd1 << w_sz) - 4'd1);
  assign w_misaligned = |(req_addr_i[2:0] & w_lowmask);
  assign w_fault      = !w_legal || (!MISALIGN_EN && w_misaligned);
  assign w_base       = req_addr_i & ~ADDR_W'(W - 1);

  always_comb begin
    w_legal = 1'b0;
    if (req_we_i) begin
      w_legal = !req_funct3_i[2] && ((w_sz != 2'd3) || (XLEN == 64));
    end else begin
      case (req_funct3_i)
        3'd0, 3'd1, 3'd2, 3'd4, 3'd5: w_legal = 1'b1;
        3'd3, 3'd6:                   w_legal = (XLEN == 64);
        default:                      w_legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    w_mask = '0;
    case (w_sz)
      2'd0:    w_mask = (2*W)'(8'h01);
      2'd1:    w_mask = (2*W)'(8'h03);
      2'd2:    w_mask = (2*W)'(8'h0F);
      default: w_mask = (2*W)'(8'hFF);
    endcase
  end

  // Shift across a double-width window; the upper half is the second beat.
  assign w_be2    = w_mask << w_off;
  assign w_wdata2 = {{XLEN{1'b0}}, req_wdata_i} << {w_off, 3'b000};

  assign w_rd_lo   = (r_state == S_WAIT1) ? r_rdata0 : bus_rdata_i;
  assign w_rd_hi   = (r_state == S_WAIT1) ? bus_rdata_i : '0;
  assign w_pair    = {w_rd_hi, w_rd_lo} >> {r_off, 3'b000};
  assign w_wb_data = extend(w_pair[XLEN-1:0], r_f3);

  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] v, input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    extend = f3[2] ? XLEN'(v[7:0])  : XLEN'(signed'(v[7:0]));
      2'd1:    extend = f3[2] ? XLEN'(v[15:0]) : XLEN'(signed'(v[15:0]));
      2'd2:    extend = f3[2] ? XLEN'(v[31:0]) : XLEN'(signed'(v[31:0]));
      default: extend = v;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_state     <= S_IDLE;
      bus_valid_o <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_be_o    <= '0;
      bus_wdata_o <= '0;
      wb_valid_o  <= 1'b0;
      wb_rd_o     <= '0;
      wb_data_o   <= '0;
      done_o      <= 1'b0;
      fault_o     <= 1'b0;
      r_we        <= 1'b0;
      r_f3        <= '0;
      r_rd        <= '0;
      r_off       <= '0;
      r_split     <= 1'b0;
      r_addr1     <= '0;
      r_be1       <= '0;
      r_wdata1    <= '0;
      r_rdata0    <= '0;
    end else begin
      done_o     <= 1'b0;
      fault_o    <= 1'b0;
      wb_valid_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid_i) begin
            r_we     <= req_we_i;
            r_f3     <= req_funct3_i;
            r_rd     <= req_rd_i;
            r_off    <= w_off;
            r_split  <= w_split;
            r_addr1  <= w_base + ADDR_W'(W);
            r_be1    <= w_be2[2*W-1:W];
            r_wdata1 <= w_wdata2[2*XLEN-1:XLEN];
            if (w_fault) begin
              r_state <= S_FAULT;
              fault_o <= 1'b1;
              done_o  <= 1'b1;
            end else begin
              r_state     <= S_ISSUE0;
              bus_valid_o <= 1'b1;
              bus_we_o    <= req_we_i;
              bus_addr_o  <= w_base;
              bus_be_o    <= w_be2[W-1:0];
              bus_wdata_o <= w_wdata2[XLEN-1:0];
            end
          end
        end
        S_ISSUE0: begin
          if (bus_ready_i) begin
            if (r_we && r_split) begin
              r_state     <= S_ISSUE1;
              bus_addr_o  <= r_addr1;
              bus_be_o    <= r_be1;
              bus_wdata_o <= r_wdata1;
            end else begin
              bus_valid_o <= 1'b0;
              if (r_we) begin
                r_state <= S_DONE;
                done_o  <= 1'b1;
              end else begin
                r_state <= S_WAIT0;
              end
            end
          end
        end
        S_WAIT0: begin
          if (bus_rvalid_i) begin
            r_rdata0 <= bus_rdata_i;
            if (r_split) begin
              r_state     <= S_ISSUE1;
              bus_valid_o <= 1'b1;
              bus_addr_o  <= r_addr1;
              bus_be_o    <= r_be1;
            end else begin
              r_state    <= S_DONE;
              done_o     <= 1'b1;
              wb_valid_o <= 1'b1;
              wb_rd_o    <= r_rd;
              wb_data_o  <= w_wb_data;
            end
          end
        end
        S_ISSUE1: begin
          if (bus_ready_i) begin
            bus_valid_o <= 1'b0;
            if (r_we) begin
              r_state <= S_DONE;
              done_o  <= 1'b1;
            end else begin
              r_state <= S_WAIT1;
            end
          end
        end
        S_WAIT1: begin
          if (bus_rvalid_i) begin
            r_state    <= S_DONE;
            done_o     <= 1'b1;
            wb_valid_o <= 1'b1;
            wb_rd_o    <= r_rd;
            wb_data_o  <= w_wb_data;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_aligner.sv
// Scoreboard bench for lsu_aligner (XLEN=32): byte-level reference model, random bus
// back-pressure and response delay, plus a MISALIGN_EN=0 instance for fault behaviour.
module tb_lsu_aligner;
  localparam int XLEN = 32;
  localparam int AW   = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic arst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic            req_valid_i, req_ready_o, req_we_i;
  logic [2:0]      req_funct3_i;
  logic [AW-1:0]   req_addr_i;
  logic [XLEN-1:0] req_wdata_i;
  logic [4:0]      req_rd_i;
  logic            bus_valid_o, bus_ready_i, bus_we_o, bus_rvalid_i;
  logic [AW-1:0]   bus_addr_o;
  logic [3:0]      bus_be_o;
  logic [XLEN-1:0] bus_wdata_o, bus_rdata_i;
  logic            wb_valid_o, done_o, fault_o;
  logic [4:0]      wb_rd_o;
  logic [XLEN-1:0] wb_data_o;
  logic [2:0]      dbg_state;

  logic            q0_valid, q0_ready, q0_we;
  logic [2:0]      q0_f3;
  logic [AW-1:0]   q0_addr;
  logic [XLEN-1:0] q0_wdata;
  logic            b0_valid, b0_we, wb0_valid, done0, fault0;
  logic [AW-1:0]   b0_addr;
  logic [3:0]      b0_be;
  logic [XLEN-1:0] b0_wdata, wb0_data;
  logic [4:0]      wb0_rd;
  logic [2:0]      dbg_state0;
  logic            b0_ready = 1'b1;
  logic            b0_rvalid = 1'b0;
  logic [XLEN-1:0] b0_rdata = '0;

  lsu_aligner #(.XLEN(32), .ADDR_W(32), .MISALIGN_EN(1'b1)) dut (
    .clk(clk), .arst_n(arst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .req_rd_i(req_rd_i), .bus_valid_o(bus_valid_o), .bus_ready_i(bus_ready_i),
    .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o),
    .bus_wdata_o(bus_wdata_o), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .done_o(done_o), .fault_o(fault_o), .dbg_state_o(dbg_state)
  );

  lsu_aligner #(.XLEN(32), .ADDR_W(32), .MISALIGN_EN(1'b0)) dut0 (
    .clk(clk), .arst_n(arst_n),
    .req_valid_i(q0_valid), .req_ready_o(q0_ready), .req_we_i(q0_we),
    .req_funct3_i(q0_f3), .req_addr_i(q0_addr), .req_wdata_i(q0_wdata),
    .req_rd_i(5'd1), .bus_valid_o(b0_valid), .bus_ready_i(b0_ready),
    .bus_we_o(b0_we), .bus_addr_o(b0_addr), .bus_be_o(b0_be),
    .bus_wdata_o(b0_wdata), .bus_rvalid_i(b0_rvalid), .bus_rdata_i(b0_rdata),
    .wb_valid_o(wb0_valid), .wb_rd_o(wb0_rd), .wb_data_o(wb0_data),
    .done_o(done0), .fault_o(fault0), .dbg_state_o(dbg_state0)
  );

  typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } beat_t;
  typedef struct { logic fault; logic is_load; logic [4:0] rd; logic [31:0] data; int lat; int acc; } done_t;
  typedef struct { logic [31:0] a; int due; } rsp_t;

  beat_t exp_beat_q[$];
  done_t exp_done_q[$];
  rsp_t  rsp_q[$];
  logic [31:0] mem [logic [31:0]];

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;
  bit zw = 1'b1;
  bit rand_mode = 1'b0;
  int resp_delay = 0;
  int stall_left = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s actual=event required=none at cycle %0d", name, cyc);
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] aw);
    if (mem.exists(aw)) return mem[aw];
    return (aw * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] w;
    w = mem_word({a[31:2], 2'b00});
    return 8'(w >> (8 * a[1:0]));
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  // Bus slave: random back-pressure, one read response per read beat after a delay.
  logic        hs_seen;
  logic [31:0] hs_addr;
  always @(negedge clk) begin
    hs_seen = arst_n && bus_valid_o && bus_ready_i && !bus_we_o;
    hs_addr = bus_addr_o;
  end

  initial begin
    bus_ready_i = 1'b1; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
    forever begin
      @(posedge clk); #1;
      if (hs_seen) begin
        rsp_t r;
        r.a = hs_addr;
        r.due = cyc + (rand_mode ? int'($urandom_range(0, 2)) : resp_delay);
        rsp_q.push_back(r);
      end
      bus_rvalid_i = 1'b0;
      if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = mem_word(rsp_q[0].a);
        void'(rsp_q.pop_front());
      end
      if (stall_left > 0 && bus_valid_o) begin
        bus_ready_i = 1'b0;
        stall_left--;
      end else begin
        bus_ready_i = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // Monitor: beats, command stability under back-pressure, completions.
  bit    p_stall = 1'b0;
  beat_t p_beat;
  always @(negedge clk) begin
    if (!arst_n) begin
      p_stall = 1'b0;
    end else begin
      if (p_stall) begin
        chk("stall_valid", bus_valid_o, 1'b1);
        chk("stall_we", bus_we_o, p_beat.we);
        chk("stall_addr", bus_addr_o, p_beat.addr);
        chk("stall_be", bus_be_o, p_beat.be);
        chk("stall_wdata", bus_wdata_o, p_beat.wdata);
      end
      p_stall = bus_valid_o && !bus_ready_i;
      p_beat = '{we: bus_we_o, addr: bus_addr_o, be: bus_be_o, wdata: bus_wdata_o};
      if (bus_valid_o && bus_ready_i) begin
        if (exp_beat_q.size() == 0) fail_now("unexpected_beat");
        else begin
          beat_t e;
          e = exp_beat_q.pop_front();
          chk("beat_we", bus_we_o, e.we);
          chk("beat_addr", bus_addr_o, e.addr);
          chk("beat_be", bus_be_o, e.be);
          if (e.we) chk("beat_wdata", bus_wdata_o & lane_mask(e.be), e.wdata);
        end
      end
      if (done_o) begin
        n_done++;
        if (exp_done_q.size() == 0) fail_now("unexpected_done");
        else begin
          done_t d;
          d = exp_done_q.pop_front();
          chk("fault", fault_o, d.fault);
          chk("wb_valid", wb_valid_o, d.is_load && !d.fault);
          if (d.is_load && !d.fault) begin
            chk("wb_rd", wb_rd_o, d.rd);
            chk("wb_data", wb_data_o, d.data);
          end
          if (d.lat >= 0) chk("latency", 64'(cyc - d.acc + 1), 64'(d.lat));
          chk("beats_left", 64'(exp_beat_q.size()), 64'd0);
        end
      end else begin
        if (wb_valid_o) fail_now("wb_without_done");
        if (fault_o) fail_now("fault_without_done");
      end
    end
  end

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd);
    int n, off, pos, t, target;
    bit legal, split;
    logic [63:0] val;
    beat_t bt[2];
    done_t d;
    n = 1 << f3[1:0];
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    off = int'(addr % 4);
    split = (off + n) > 4;
    for (int b = 0; b < 2; b++) begin
      bt[b].we = we;
      bt[b].addr = (addr - 32'(off)) + 32'(4 * b);
      bt[b].be = '0;
      bt[b].wdata = '0;
    end
    val = '0;
    if (legal) begin
      for (int i = 0; i < n; i++) begin
        pos = off + i;
        bt[pos / 4].be[pos % 4] = 1'b1;
        bt[pos / 4].wdata[8 * (pos % 4) +: 8] = wdata[8 * i +: 8];
        val = val | (64'(mem_byte(addr + 32'(i))) << (8 * i));
      end
      if (!f3[2] && val[8 * n - 1]) val = val | ~((64'd1 << (8 * n)) - 64'd1);
      exp_beat_q.push_back(bt[0]);
      if (split) exp_beat_q.push_back(bt[1]);
    end
    d.fault = !legal;
    d.is_load = !we;
    d.rd = rd;
    d.data = val[31:0];
    d.lat = !zw ? -1 : (!legal ? 1 : (we ? (split ? 3 : 2) : (split ? 5 : 3)));
    @(posedge clk); #1;
    req_valid_i = 1'b1; req_we_i = we; req_funct3_i = f3;
    req_addr_i = addr; req_wdata_i = wdata; req_rd_i = rd;
    t = 0;
    forever begin
      @(negedge clk);
      if (req_ready_o) break;
      t++;
      if (t > 50) break;
    end
    if (t > 50) begin
      fail_now("accept_timeout");
      req_valid_i = 1'b0;
      exp_beat_q.delete();
      return;
    end
    target = n_done + 1;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    d.acc = cyc;
    exp_done_q.push_back(d);
    t = 0;
    while (n_done < target && t < 300) begin
      @(posedge clk);
      t++;
    end
    if (n_done < target) begin
      fail_now("done_timeout");
      exp_done_q.delete();
      exp_beat_q.delete();
      #1 arst_n = 1'b0;
      @(posedge clk); #1 arst_n = 1'b1;
    end
  endtask

  task automatic req0(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input bit exp_fault, input int exp_lat);
    int acc, lat_seen;
    bit saw_bus, saw_fault, saw_wb;
    @(posedge clk); #1;
    q0_valid = 1'b1; q0_we = we; q0_f3 = f3; q0_addr = addr; q0_wdata = 32'h12345678;
    @(negedge clk);
    chk("m0_ready", q0_ready, 1'b1);
    @(posedge clk); #1;
    q0_valid = 1'b0;
    acc = cyc;
    lat_seen = -1; saw_bus = 1'b0; saw_fault = 1'b0; saw_wb = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (b0_valid) saw_bus = 1'b1;
      if (wb0_valid) saw_wb = 1'b1;
      if (done0 && lat_seen < 0) begin
        lat_seen = cyc - acc + 1;
        saw_fault = fault0;
      end
    end
    chk("m0_fault", saw_fault, exp_fault);
    chk("m0_latency", 64'(lat_seen), 64'(exp_lat));
    chk("m0_wb", saw_wb, 1'b0);
    if (exp_fault) chk("m0_no_bus", saw_bus, 1'b0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_bus_valid"}, bus_valid_o, 1'b0);
    chk({tag, "_bus_we"}, bus_we_o, 1'b0);
    chk({tag, "_bus_addr"}, bus_addr_o, 32'h0);
    chk({tag, "_bus_be"}, bus_be_o, 4'h0);
    chk({tag, "_bus_wdata"}, bus_wdata_o, 32'h0);
    chk({tag, "_wb"}, {wb_valid_o, wb_rd_o, wb_data_o}, 38'h0);
    chk({tag, "_done_fault"}, {done_o, fault_o}, 2'b00);
    chk({tag, "_ready"}, req_ready_o, 1'b1);
  endtask

  task automatic reset_test();
    int wbc;
    zw = 1'b0;
    resp_delay = 3;
    exp_beat_q.push_back('{we: 1'b0, addr: 32'h4000, be: 4'hF, wdata: 32'h0});
    @(posedge clk); #1;
    req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = 3'b010;
    req_addr_i = 32'h4000; req_rd_i = 5'd9;
    @(negedge clk);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    @(posedge clk); #1;
    arst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_idle_outputs("midreset");
    @(posedge clk); #1;
    arst_n = 1'b1;
    wbc = 0;
    repeat (8) begin
      @(negedge clk);
      if (wb_valid_o || done_o) wbc++;
    end
    chk("late_rvalid_wb", 64'(wbc), 64'd0);
    chk("reset_beats_left", 64'(exp_beat_q.size()), 64'd0);
    resp_delay = 0;
  endtask

  initial begin
    arst_n = 1'b0;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_funct3_i = '0;
    req_addr_i = '0; req_wdata_i = '0; req_rd_i = '0;
    q0_valid = 1'b0; q0_we = 1'b0; q0_f3 = '0; q0_addr = '0; q0_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    arst_n = 1'b1;

    mem[32'h1000] = 32'h80112233;
    mem[32'h3000] = 32'h44332211;
    mem[32'h3004] = 32'h88776655;
    do_req(1'b0, 3'b000, 32'h1003, 32'h0, 5'd5);
    do_req(1'b0, 3'b100, 32'h1003, 32'h0, 5'd6);
    do_req(1'b1, 3'b001, 32'h2002, 32'h0000BEEF, 5'd0);
    do_req(1'b0, 3'b010, 32'h3001, 32'h0, 5'd7);
    do_req(1'b0, 3'b011, 32'h3000, 32'h0, 5'd8);
    do_req(1'b1, 3'b010, 32'hFFFFFFFE, 32'hAABBCCDD, 5'd0);
    do_req(1'b0, 3'b101, 32'h3003, 32'h0, 5'd0);
    do_req(1'b1, 3'b100, 32'h3000, 32'h1, 5'd0);
    do_req(1'b0, 3'b111, 32'h3000, 32'h0, 5'd3);

    req0(1'b0, 3'b010, 32'h3001, 1'b1, 1);
    req0(1'b0, 3'b011, 32'h3000, 1'b1, 1);
    req0(1'b1, 3'b001, 32'h2001, 1'b1, 1);
    req0(1'b1, 3'b010, 32'h3004, 1'b0, 2);

    zw = 1'b0;
    stall_left = 3;
    do_req(1'b1, 3'b010, 32'h5001, 32'hCAFEF00D, 5'd0);
    stall_left = 3;
    do_req(1'b0, 3'b001, 32'h5003, 32'h0, 5'd11);

    reset_test();

    rand_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
             5'($urandom_range(0, 31)));
    end
    rand_mode = 1'b0;
    repeat (5) @(posedge clk);
    chk("end_done_q", 64'(exp_done_q.size()), 64'd0);
    chk("end_beat_q", 64'(exp_beat_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lsu_aligner.md
# lsu_aligner

Parametrised load/store alignment unit sitting between the execute stage and the data-memory bus, replacing combinational read-modify-write store merging with byte-enable bus writes. It accepts one load/store request at a time and sign- or zero-extends load data for the integer register file. Accesses that cross a bus-word boundary are split into two bus beats, or faulted, depending on configuration. Supports XLEN 32 and 64, including the RV64 LD/LWU/SD forms.

## Interface
- XLEN, 32: data/bus width, 32 or 64; W = XLEN/8 bytes per beat.
- ADDR_W, 32: byte address width.
- MISALIGN_EN, 1: 1 splits cross-word accesses into two beats; 0 faults any non-naturally-aligned access.

- clk  in  1  clock.
- arst_n  in  1  reset, synchronous, active-low.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  unit idle, can accept a request.
- req_we_i  in  1  1 = store, 0 = load.
- req_funct3_i  in  3  RISC-V load/store funct3.
- req_addr_i  in  ADDR_W  byte address.
- req_wdata_i  in  XLEN  store data, right-aligned.
- req_rd_i  in  5  load destination register.
- bus_valid_o  out  1  bus command valid.
- bus_ready_i  in  1  bus command accepted.
- bus_we_o  out  1  bus write.
- bus_addr_o  out  ADDR_W  W-aligned beat address.
- bus_be_o  out  W  byte enables.
- bus_wdata_o  out  XLEN  lane-shifted write data.
- bus_rvalid_i  in  1  read data valid.
- bus_rdata_i  in  XLEN  read data.
- wb_valid_o  out  1  one-cycle load writeback strobe.
- wb_rd_o  out  5  writeback register.
- wb_data_o  out  XLEN  extended load data.
- done_o  out  1  one-cycle completion pulse for any request, fault included.
- fault_o  out  1  one-cycle fault pulse: misaligned access (MISALIGN_EN=0) or illegal funct3.

## Operation
- Size: funct3[1:0] = 00 byte, 01 half, 10 word, 11 double. funct3[2] = 1 selects zero-extension, loads only.
- Legal loads: LB, LH, LW, LBU, LHU; LD and LWU only when XLEN=64. Legal stores: SB, SH, SW; SD only when XLEN=64. Any other encoding is illegal and faults.
- off = addr mod W. An access is split when off + size > W.
- MISALIGN_EN=0: fault when addr mod size != 0.
- MISALIGN_EN=1: misaligned accesses within one word complete in a single beat.
- Beat 0:
  - addr = addr & ~(W-1).
  - be = size-byte mask << off, truncated to W bits.
  - wdata = req_wdata << 8·off.
- Beat 1 (split only):
  - addr = beat0 addr + W, modulo 2^ADDR_W, so it wraps to 0 at the top of the address space.
  - be = remaining low-byte mask.
  - wdata = req_wdata >> 8·(W − off).
- Load assembly: bytes come from beat0 lanes off..W−1, then beat1 lanes 0.., little-endian. The assembled value is extended to XLEN per funct3.
- FSM states:
  - IDLE: req_ready_o = 1. On accept, a legal request goes to ISSUE0; a faulting request goes to FAULT.
  - ISSUE0: hold bus_valid_o until bus_ready_i. Then a load goes to WAIT0; a store goes to ISSUE1 if split, else DONE.
  - WAIT0: on bus_rvalid_i, capture the data; go to ISSUE1 if split, else DONE.
  - ISSUE1 / WAIT1: same as ISSUE0 / WAIT0 for the second beat, then DONE.
  - DONE: pulse done_o; for loads also pulse wb_valid_o with wb_rd_o and wb_data_o. Return to IDLE.
  - FAULT: pulse fault_o and done_o, then IDLE. No bus traffic, no writeback.
- Stores never assert wb_valid_o.
- Loads with rd = 0 still complete normally; the register file ignores the write.
- All bus, wb and pulse outputs are registered.

## Timing
- Reset: synchronous. While arst_n = 0 at a clk edge, the FSM goes to IDLE and every output register clears to 0: bus_*, wb_*, done_o, fault_o. req_ready_o = 1 after reset.
- Reset mid-operation aborts the request. Any in-flight bus response is discarded, and the bus is reset in the same cycle.
- Request accept: req_valid_i & req_ready_o at edge T.
- Beat 0 command: bus_valid_o = 1 from T+1.
- Bus command stability: while bus_valid_o = 1 and bus_ready_i = 0, bus_we_o, bus_addr_o, bus_be_o and bus_wdata_o are held stable.
- Read response: bus_rvalid_i arrives no earlier than one cycle after the command handshake. Exactly one response per read beat.
- Zero-wait latencies:
  - Aligned load: handshake T+1, rvalid T+2, wb_valid_o/done_o T+3.
  - Aligned store: handshake T+1, done_o T+2.
  - Split access: +2 cycles for a load, +1 cycle for a store.
  - Fault: fault_o/done_o at T+1.
- Next accept: req_ready_o returns the cycle after DONE/FAULT, giving one request per ≥3 cycles (≥2 for a fault).

## Test plan
- XLEN=32, LB at 0x1003, rdata 0x80112233 -> bus_be 1000, wb_data 0xFFFFFF80. LBU at the same address -> wb_data 0x00000080.
- SH at 0x2002, wdata 0x0000BEEF -> bus_addr 0x2000, be 1100, wdata 0xBEEF0000, bus_we 1. done_o at T+2, no wb_valid_o.
- MISALIGN_EN=1, LW at 0x3001, rdata0 0x44332211, rdata1 0x88776655:
  - beat0 0x3000/1110, beat1 0x3004/0001.
  - wb_data 0x55443322, wb_valid_o at T+5.
- MISALIGN_EN=0, LW at 0x3001 -> fault_o and done_o at T+1, bus_valid_o never asserts. Likewise LD at XLEN=32 -> fault_o.
- MISALIGN_EN=1, SW 0xAABBCCDD at 0xFFFFFFFE:
  - beat0 0xFFFFFFFC/1100/0xCCDD0000.
  - beat1 0x00000000/0011/0x0000AABB.
- bus_ready_i low for 3 cycles -> beat fields stable throughout. arst_n low during WAIT0 -> all outputs 0 next cycle, then IDLE; a late rvalid produces no wb_valid_o.
